// File: rtl/pdm_cic_if.sv
// PDM input stream and PCM output strobe bundle for the CIC decimator.
// The master drives PDM bits and receives PCM; the slave is the decimator.
interface pdm_cic_if;
  logic        pdm_data;
  logic        pdm_valid;
  logic [15:0] y_out;
  logic        y_out_valid;

  modport master (
    output pdm_data,
    output pdm_valid,
    input  y_out,
    input  y_out_valid
  );

  modport slave (
    input  pdm_data,
    input  pdm_valid,
    output y_out,
    output y_out_valid
  );
endinterface

// File: rtl/pdm_cic_decim.sv
// Fourth-order CIC decimator (M=1): 1-bit PDM in, saturated 16-bit Q15 PCM out
// at 1/DECIM of the accepted PDM strobe rate.
module pdm_cic_decim #(
  parameter int unsigned DECIM_LOG2 = 5,
  parameter int unsigned ACC_W      = 4 * DECIM_LOG2 + 2
) (
  input  logic     clk,
  input  logic     reset_n,
  pdm_cic_if.slave bus
);

  localparam int unsigned SHIFT = 4 * DECIM_LOG2 - 15;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-32768);

  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d, i4_q, i4_d;
  logic [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic [ACC_W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c4_q, c4_d;
  logic dec_stb_q, dec_stb_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
  logic [15:0] y_out_q, y_out_d;
  logic        y_out_valid_q, y_out_valid_d;

  logic [ACC_W-1:0]        x_c;
  logic signed [ACC_W-1:0] q_c;
  logic [15:0]             y_sat_c;

  always_comb begin
    cnt_d         = cnt_q;
    i1_d          = i1_q;
    i2_d          = i2_q;
    i3_d          = i3_q;
    i4_d          = i4_q;
    d1_d          = d1_q;
    d2_d          = d2_q;
    d3_d          = d3_q;
    d4_d          = d4_q;
    c1_d          = c1_q;
    c2_d          = c2_q;
    c3_d          = c3_q;
    c4_d          = c4_q;
    dec_stb_d     = 1'b0;
    y_out_d       = y_out_q;
    y_out_valid_d = 1'b0;

    // PDM 1 -> +1, 0 -> -1 (all ones in two's complement)
    x_c = bus.pdm_data ? ACC_W'(1) : {ACC_W{1'b1}};

    // Registered integrator chain: each stage adds its predecessor's old value
    if (bus.pdm_valid) begin
      i1_d      = i1_q + x_c;
      i2_d      = i2_q + i1_q;
      i3_d      = i3_q + i2_q;
      i4_d      = i4_q + i3_q;
      cnt_d     = cnt_q + DECIM_LOG2'(1);
      dec_stb_d = (cnt_q == CNT_LAST);
    end

    s1_d = dec_stb_q;
    s2_d = s1_q;
    s3_d = s2_q;
    s4_d = s3_q;

    if (dec_stb_q) begin
      c1_d = i4_q - d1_q;
      d1_d = i4_q;
    end
    if (s1_q) begin
      c2_d = c1_q - d2_q;
      d2_d = c1_q;
    end
    if (s2_q) begin
      c3_d = c2_q - d3_q;
      d3_d = c2_q;
    end
    if (s3_q) begin
      c4_d = c3_q - d4_q;
      d4_d = c3_q;
    end

    // Normalize DECIM^4 gain to Q15; only +full-scale actually clips
    q_c = $signed(c4_q) >>> SHIFT;
    if (q_c > Q_MAX) begin
      y_sat_c = 16'h7fff;
    end else if (q_c < Q_MIN) begin
      y_sat_c = 16'h8000;
    end else begin
      y_sat_c = q_c[15:0];
    end

    if (s4_q) begin
      y_out_d       = y_sat_c;
      y_out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      i1_q          <= '0;
      i2_q          <= '0;
      i3_q          <= '0;
      i4_q          <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      d3_q          <= '0;
      d4_q          <= '0;
      c1_q          <= '0;
      c2_q          <= '0;
      c3_q          <= '0;
      c4_q          <= '0;
      dec_stb_q     <= 1'b0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      s4_q          <= 1'b0;
      y_out_q       <= '0;
      y_out_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      i1_q          <= i1_d;
      i2_q          <= i2_d;
      i3_q          <= i3_d;
      i4_q          <= i4_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      d3_q          <= d3_d;
      d4_q          <= d4_d;
      c1_q          <= c1_d;
      c2_q          <= c2_d;
      c3_q          <= c3_d;
      c4_q          <= c4_d;
      dec_stb_q     <= dec_stb_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      s4_q          <= s4_d;
      y_out_q       <= y_out_d;
      y_out_valid_q <= y_out_valid_d;
    end
  end

  assign bus.y_out       = y_out_q;
  assign bus.y_out_valid = y_out_valid_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Self-checking bench for pdm_cic_decim: unbounded-integer CIC reference model
// feeding an expected-sample queue, compared as PCM samples emerge.
module tb_pdm_cic_decim;

  localparam int DECIM_LOG2 = 5;
  localparam int DECIM      = 1 << DECIM_LOG2;
  localparam int SHIFT      = 4 * DECIM_LOG2 - 15;

  logic clk;
  logic reset_n;
  pdm_cic_if bus ();

  pdm_cic_decim #(.DECIM_LOG2(DECIM_LOG2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  longint mi1, mi2, mi3, mi4, md1, md2, md3, md4;
  int     mcnt;
  int     exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    mi1 = 0; mi2 = 0; mi3 = 0; mi4 = 0;
    md1 = 0; md2 = 0; md3 = 0; md4 = 0;
    mcnt = 0;
    exp_q.delete();
  endtask

  // Reference CIC in wide integers; comb differences are exact without wrap
  task automatic model_accept(input bit d);
    longint x, c1, c2, c3, c4, q;
    x = d ? 64'sd1 : -64'sd1;
    mi4 += mi3; mi3 += mi2; mi2 += mi1; mi1 += x;
    mcnt++;
    if (mcnt == DECIM) begin
      mcnt = 0;
      c1 = mi4 - md1; md1 = mi4;
      c2 = c1 - md2;  md2 = c1;
      c3 = c2 - md3;  md3 = c2;
      c4 = c3 - md4;  md4 = c3;
      q = c4 >>> SHIFT;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      exp_q.push_back(int'(q));
    end
  endtask

  // Drive one cycle from a negedge, sample outputs at the following negedge
  task automatic step(input bit v, input bit d, output bit ov, output int oy);
    bus.pdm_valid = v;
    bus.pdm_data  = d;
    if (v) model_accept(d);
    @(posedge clk);
    @(negedge clk);
    ov = bus.y_out_valid;
    oy = int'($signed(bus.y_out));
  endtask

  task automatic apply_reset();
    bus.pdm_valid = 1'b0;
    bus.pdm_data  = 1'b0;
    reset_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bit ov;
    int oy, t_acc, early, waited;
    apply_reset();
    checks++;
    if (bus.y_out !== 16'h0 || bus.y_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: y_out=%0h valid=%0b, required 0/0", bus.y_out, bus.y_out_valid);
    end
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, ov, oy);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.y_out !== 16'h0 || bus.y_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: y_out=%0h valid=%0b, required 0/0", bus.y_out, bus.y_out_valid);
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    early = 0;
    for (int i = 0; i < DECIM - 1; i++) begin
      step(1'b1, (i % 3) != 0, ov, oy);
      if (ov) early++;
    end
    step(1'b1, 1'b1, ov, oy);
    if (ov) early++;
    t_acc = cyc;
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL reset_no_early_output: got %0d outputs, required 0", early);
    end
    waited = 0;
    ov = 1'b0;
    while (!ov && waited < 16) begin
      step(1'b0, 1'b0, ov, oy);
      waited++;
    end
    checks++;
    if (!ov || (cyc - t_acc) !== 5) begin
      errors++;
      $display("FAIL reset_first_latency: got %0d clocks (seen=%0b), required 5", cyc - t_acc, ov);
    end
    checks++;
    if (exp_q.size() == 0 || oy !== exp_q[0]) begin
      errors++;
      $display("FAIL reset_first_value: got %0d, required %0d", oy, (exp_q.size() != 0) ? exp_q[0] : 0);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  // Stream a pattern; mode 0=ones 1=zeros 2=alternating 3=1110
  task automatic test_stream(input string name, input int mode, input int period,
                             input int nstb, input int settled);
    bit ov, d;
    int oy, k, nout, last, expv;
    apply_reset();
    k = 0; nout = 0; last = 0;
    for (int i = 0; i < nstb * period + 12; i++) begin
      case (mode)
        0: d = 1'b1;
        1: d = 1'b0;
        2: d = (k % 2) == 0;
        default: d = (k % 4) != 3;
      endcase
      if (k < nstb && (i % period) == 0) begin
        step(1'b1, d, ov, oy);
        k++;
      end else begin
        step(1'b0, 1'b0, ov, oy);
      end
      if (ov) begin
        nout++;
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 99999;
        checks++;
        if (oy !== expv) begin
          errors++;
          $display("FAIL %s_model out%0d: got %0d, required %0d", name, nout, oy, expv);
        end
        if (nout >= 6) begin
          checks++;
          if (oy !== settled) begin
            errors++;
            $display("FAIL %s_settled out%0d: got %0d, required %0d", name, nout, oy, settled);
          end
        end
        if (nout > 1) begin
          checks++;
          if ((cyc - last) !== DECIM * period) begin
            errors++;
            $display("FAIL %s_spacing out%0d: got %0d, required %0d", name, nout, cyc - last, DECIM * period);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (nout !== nstb / DECIM || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs (%0d pending), required %0d", name, nout, exp_q.size(), nstb / DECIM);
    end
  endtask

  task automatic test_all_ones();    test_stream("all_ones", 0, 1, 400, 32767);     endtask
  task automatic test_all_zeros();   test_stream("all_zeros", 1, 1, 400, -32768);   endtask
  task automatic test_alternating(); test_stream("alternating", 2, 1, 400, 0);      endtask
  task automatic test_sparse();      test_stream("sparse", 0, 4, 10240, 32767);     endtask
  task automatic test_duty();        test_stream("duty_3to1", 3, 1, 2080, 16384);   endtask

  initial begin
    reset_n       = 1'b0;
    bus.pdm_valid = 1'b0;
    bus.pdm_data  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_alternating();
    test_sparse();
    test_duty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
